lock_pid_multi: RTL
===================

Name: lock_pid_multi

Overview:
- Parametrised, sample-enabled successor of the lock-loop PID controller. Sits between the lock-in demodulator output and the DAC/actuator mux.
- Error generation, P/I/D paths, output offset and output clamp are unchanged in purpose from the current PID.
- New relative to the current PID: generic widths, arbitrary binary shifts, a valid handshake, a programmable integrator anti-windup limit, a programmable output window and saturation flags.

Parameters:
- DW, 14: signed data width of input, set point, offset and output.
- KW, 14: signed gain width (Kp, Ki, Kd).
- SW, 5: width of the shift-select inputs. Shift range is 0..2**SW-1.
- DECW, 4: width of the derivative decimation select.
- IGW, 8: integrator guard bits above the maximum shifted range.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, synchronous, active-low.
- dat_i  in  DW  signed process input.
- dat_valid_i  in  1  sample strobe. The pipeline advances only when high.
- set_sp_i  in  DW  signed set point.
- set_ofs_i  in  DW  signed output offset.
- set_kp_i / set_ki_i / set_kd_i  in  KW each  signed gains.
- psr_i / isr_i  in  SW each  right-shift applied to the P and I terms.
- dsr_i  in  DECW  derivative averaging window, 2**dsr_i samples.
- int_lim_i  in  DW-1  unsigned magnitude limit of the shifted integrator term.
- out_min_i / out_max_i  in  DW each  signed output window.
- slew_i  in  DW-1  unsigned maximum output step per sample. Used only with the optional feature.
- pid_freeze_i  in  1  hold output.
- pid_ifreeze_i  in  1  stop integration.
- int_rst_i  in  1  clear integrator.
- dat_o  out  DW  signed control output.
- dat_valid_o  out  1  output strobe.
- int_sat_o  out  1  integrator clamped this sample.
- out_sat_o  out  1  output clamped this sample.

Behaviour:
- Reset (rstn_i=0 at a clock edge):
  - clears all pipeline, integrator, decimator and derivative state;
  - dat_o=0, dat_valid_o=0, int_sat_o=0, out_sat_o=0;
  - applies immediately, including mid-sample, and discards in-flight samples.
- Pipeline: four stages, each advancing only on valid.
  - S0: err = set_sp_i - dat_i, DW+1 bits.
  - S1: P, I and D products, DW+1+KW bits.
  - S2: shifts and integrator update.
  - S3: sum and clamp.
  - dat_valid_o pulses exactly 4 clocks after its dat_valid_i, one pulse per input sample.
  - Back-to-back valids are supported at full rate. Gaps stall nothing and register nothing.
- Shifts: arithmetic right shift (sign-preserving, truncate toward minus infinity). A shift of 0 passes the value through.
- P term: (err*Kp) >>> psr_i.
- I term:
  - Accumulator width DW+1+KW+2**SW+IGW, so it cannot wrap.
  - acc_next = acc + (pid_ifreeze_i ? 0 : err*Ki).
  - Anti-windup: acc_next is clamped to ±(int_lim_i << isr_i). The I term is acc >>> isr_i.
  - int_sat_o=1 on any sample where the clamp is active.
  - int_rst_i has priority over ifreeze and integration: acc=0 on the next valid edge, int_sat_o=0.
  - Lowering int_lim_i below the current |acc| clamps on the next valid sample.
- D term:
  - A boxcar accumulates err over 2**dsr_i valid samples with a wrap-free counter.
  - At window end, avg = sum >>> dsr_i and d = (avg - avg_prev)*Kd; avg_prev is then updated.
  - d is held between window ends.
  - A change of dsr_i restarts the window on the next valid sample.
- Output:
  - sum = P + I + D + set_ofs_i at full width, then clamped to [out_min_i, out_max_i]; out_sat_o flags clamping.
  - If out_min_i > out_max_i, the output is out_min_i and out_sat_o=1.
  - pid_freeze_i holds dat_o at its last value; dat_valid_o still pulses and the integrator keeps running.
  - When freeze is released, the new value appears at the next dat_valid_o.

Optional Feature:
- LOCK_PID_SLEW_EN defined: the output passes through a slew limiter after the clamp. Each dat_valid_o, dat_o moves toward the clamped target by at most slew_i. slew_i=0 holds the output. out_sat_o is unchanged by slewing.
- Undefined: slew_i is ignored and the clamped target goes straight to dat_o.
- Latency is 4 in both cases.

Decomposition:
- Package lock_pid_pkg holds:
  - width helper functions (product and accumulator width from DW/KW/SW/IGW);
  - the signed arithmetic-shift-right function;
  - the generic signed clamp function (value, lo, hi -> value, flag).
- One sub-module, lock_pid_deriv, holds the decimating boxcar, the difference and the Kd multiply with hold. Its interface is clk_i, rstn_i, valid, err, dsr, kd, d_o.

Test Plan:
All cases use DW=KW=14 and SW=5.
- sp=1000, dat=0, Kp=1024, psr=10, Ki=Kd=0, continuous valid -> dat_o=1000 on the 4th clock after the first valid; dat_valid_o mirrors the valid pattern delayed by 4.
- Kp=0, Ki=1, isr=4, err=16, lim=8191 -> the I term increments by 1 per valid sample; dat_o = n after n samples.
- Ki=1000, isr=0, lim=100, err=+500 -> the I term saturates at 100 with int_sat_o=1. Then err=-500 -> the output falls the next sample (no windup recovery delay).
- out_max=200, Kp gives 5000 -> dat_o=200, out_sat_o=1. Asserting pid_freeze_i, then changing sp -> dat_o stays at 200.
- dsr=2, dat ramp -4 per sample, Kd=1 -> the D term updates every 4 samples to +16 and is held in between.
- rstn_i low for 1 clock mid-stream -> the next cycle has dat_o=0, all flags 0, no dat_valid_o for 4 clocks after the first new valid. With LOCK_PID_SLEW_EN and slew=10, a step 0->100 ramps in 10 samples.

Source files
------------

// File: rtl/lock_pid_pkg.sv
// Shared helpers for the lock-loop PID: width calculators, a signed
// arithmetic right shift and a generic signed clamp. All arithmetic helpers
// work on a common wide signed type large enough for every internal value.
package lock_pid_pkg;

  localparam int MAXW = 96;
  typedef logic signed [MAXW-1:0] wide_t;

  // Width of an error (DW+1) times gain (KW) product
  function automatic int prod_w(input int dw, input int kw);
    return dw + 1 + kw;
  endfunction

  // Integrator width: product plus the full shift range plus guard bits
  function automatic int acc_w(input int dw, input int kw, input int sw, input int igw);
    return prod_w(dw, kw) + (2 ** sw) + igw;
  endfunction

  // Sign-preserving right shift, rounds toward minus infinity
  function automatic wide_t asr(input wide_t v, input int sh);
    return v >>> sh;
  endfunction

  // Clamp v into [lo, hi]; an empty window (lo > hi) yields lo, flagged
  function automatic wide_t clamp(input wide_t v, input wide_t lo, input wide_t hi,
                                  output logic flag);
    flag = 1'b1;
    if (lo > hi)     return lo;
    else if (v < lo) return lo;
    else if (v > hi) return hi;
    flag = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/lock_pid_deriv.sv
// Derivative path: boxcar average of the error over 2**dsr valid samples,
// difference against the previous window average, times Kd. The result is
// held between window ends. A new dsr value restarts the current window.
module lock_pid_deriv
  import lock_pid_pkg::*;
#(
  parameter int EW   = 15,
  parameter int KW   = 14,
  parameter int DECW = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  valid_i,
  input  logic [EW-1:0]         err_i,
  input  logic [DECW-1:0]       dsr_i,
  input  logic [KW-1:0]         kd_i,
  output logic [EW+KW:0]        d_o
);

  localparam int CW  = 2 ** DECW;   // counts up to 2**(2**DECW-1) samples without wrap
  localparam int SMW = EW + CW;     // window sum cannot overflow
  localparam int DFW = EW + 1;
  localparam int DDW = DFW + KW;

  logic [CW-1:0]          cnt_q, cnt_d, base_cnt, last_cnt;
  logic signed [SMW-1:0]  sum_q, sum_d, base_sum, win_sum;
  logic signed [EW-1:0]   avg_prev_q, avg_prev_d, avg;
  logic signed [DFW-1:0]  diff;
  logic signed [DDW-1:0]  d_q, d_d;
  logic [DECW-1:0]        dsr_q, dsr_d;

  // Window accumulation, end-of-window average/difference and Kd multiply
  always_comb begin
    base_cnt = cnt_q;
    base_sum = sum_q;
    if (dsr_i != dsr_q) begin
      base_cnt = '0;
      base_sum = '0;
    end
    last_cnt   = (CW'(1) << dsr_i) - CW'(1);
    win_sum    = base_sum + SMW'($signed(err_i));
    avg        = EW'(asr(MAXW'(win_sum), int'(dsr_i)));
    diff       = DFW'(avg) - DFW'(avg_prev_q);
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    avg_prev_d = avg_prev_q;
    d_d        = d_q;
    dsr_d      = dsr_q;
    if (valid_i) begin
      dsr_d = dsr_i;
      if (base_cnt == last_cnt) begin
        cnt_d      = '0;
        sum_d      = '0;
        avg_prev_d = avg;
        d_d        = DDW'(diff) * DDW'($signed(kd_i));
      end else begin
        cnt_d = base_cnt + CW'(1);
        sum_d = win_sum;
      end
    end
  end

  // Derivative state registers
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q      <= '0;
      sum_q      <= '0;
      avg_prev_q <= '0;
      d_q        <= '0;
      dsr_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      avg_prev_q <= avg_prev_d;
      d_q        <= d_d;
      dsr_q      <= dsr_d;
    end
  end

  assign d_o = d_q;

endmodule

// File: rtl/lock_pid_multi.sv
// Sample-enabled lock-loop PID controller with 4-stage valid-tracked pipeline:
// error, products, shifts/integrator, sum/clamp. Optional output slew limiter
// is enabled by defining LOCK_PID_SLEW_EN; latency is 4 either way.
module lock_pid_multi
  import lock_pid_pkg::*;
#(
  parameter int DW   = 14,
  parameter int KW   = 14,
  parameter int SW   = 5,
  parameter int DECW = 4,
  parameter int IGW  = 8
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [DW-1:0]   dat_i,
  input  logic            dat_valid_i,
  input  logic [DW-1:0]   set_sp_i,
  input  logic [DW-1:0]   set_ofs_i,
  input  logic [KW-1:0]   set_kp_i,
  input  logic [KW-1:0]   set_ki_i,
  input  logic [KW-1:0]   set_kd_i,
  input  logic [SW-1:0]   psr_i,
  input  logic [SW-1:0]   isr_i,
  input  logic [DECW-1:0] dsr_i,
  input  logic [DW-2:0]   int_lim_i,
  input  logic [DW-1:0]   out_min_i,
  input  logic [DW-1:0]   out_max_i,
  input  logic [DW-2:0]   slew_i,
  input  logic            pid_freeze_i,
  input  logic            pid_ifreeze_i,
  input  logic            int_rst_i,
  output logic [DW-1:0]   dat_o,
  output logic            dat_valid_o,
  output logic            int_sat_o,
  output logic            out_sat_o
);

  localparam int EW  = DW + 1;
  localparam int PW  = prod_w(DW, KW);
  localparam int AW  = acc_w(DW, KW, SW, IGW);
  localparam int DDW = EW + 1 + KW;

  logic                  v0_q, v1_q, v2_q, vo_q;
  logic signed [EW-1:0]  err_q;
  logic signed [PW-1:0]  pprod_q, iprod_q;
  logic signed [DDW-1:0] d_w;
  logic signed [AW-1:0]  acc_q, acc_d, pterm_q, iterm_q, dterm_q;
  logic                  isat_q, isat_d, isat_o_q, osat_q, osat_d;
  logic [DW-1:0]         dat_q, dat_d;
  wide_t                 lim_w, inc_w, acc_sum_w, acc_clamp_w, sum_w, tgt_w;

  // S0: error against set point
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      v0_q  <= 1'b0;
      err_q <= '0;
    end else begin
      v0_q <= dat_valid_i;
      if (dat_valid_i) err_q <= EW'($signed(set_sp_i)) - EW'($signed(dat_i));
    end
  end

  // S1: proportional and integral products
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      v1_q    <= 1'b0;
      pprod_q <= '0;
      iprod_q <= '0;
    end else begin
      v1_q <= v0_q;
      if (v0_q) begin
        pprod_q <= PW'(err_q) * PW'($signed(set_kp_i));
        iprod_q <= PW'(err_q) * PW'($signed(set_ki_i));
      end
    end
  end

  // S1 (parallel): derivative, lands alongside the products
  lock_pid_deriv #(.EW(EW), .KW(KW), .DECW(DECW)) u_deriv (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .valid_i (v0_q),
    .err_i   (err_q),
    .dsr_i   (dsr_i),
    .kd_i    (set_kd_i),
    .d_o     (d_w)
  );

  // Integrator next state with anti-windup clamp; clear has top priority
  always_comb begin
    lim_w = MAXW'({1'b0, int_lim_i}) << isr_i;
    inc_w = '0;
    if (!pid_ifreeze_i) inc_w = MAXW'(iprod_q);
    acc_sum_w   = MAXW'(acc_q) + inc_w;
    acc_clamp_w = clamp(acc_sum_w, -lim_w, lim_w, isat_d);
    acc_d       = AW'(acc_clamp_w);
    if (int_rst_i) begin
      acc_d  = '0;
      isat_d = 1'b0;
    end
  end

  // S2: shifted terms and integrator register
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      v2_q    <= 1'b0;
      acc_q   <= '0;
      isat_q  <= 1'b0;
      pterm_q <= '0;
      iterm_q <= '0;
      dterm_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        acc_q   <= acc_d;
        isat_q  <= isat_d;
        pterm_q <= AW'(asr(MAXW'(pprod_q), int'(psr_i)));
        iterm_q <= AW'(asr(MAXW'(acc_d), int'(isr_i)));
        dterm_q <= AW'(d_w);
      end
    end
  end

`ifdef LOCK_PID_SLEW_EN
  wide_t step_w, cur_w;
`else
  logic slew_unused;
  assign slew_unused = ^slew_i;
`endif

  // Full-width sum, output window clamp, optional slew limit, freeze hold
  always_comb begin
    sum_w = MAXW'(pterm_q) + MAXW'(iterm_q) + MAXW'(dterm_q) + MAXW'($signed(set_ofs_i));
    tgt_w = clamp(sum_w, MAXW'($signed(out_min_i)), MAXW'($signed(out_max_i)), osat_d);
`ifdef LOCK_PID_SLEW_EN
    step_w = MAXW'({1'b0, slew_i});
    cur_w  = MAXW'($signed(dat_q));
    if (tgt_w > cur_w + step_w)      tgt_w = cur_w + step_w;
    else if (tgt_w < cur_w - step_w) tgt_w = cur_w - step_w;
`endif
    dat_d = pid_freeze_i ? dat_q : DW'(tgt_w);
  end

  // S3: output registers
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      vo_q     <= 1'b0;
      dat_q    <= '0;
      isat_o_q <= 1'b0;
      osat_q   <= 1'b0;
    end else begin
      vo_q <= v2_q;
      if (v2_q) begin
        dat_q    <= dat_d;
        isat_o_q <= isat_q;
        osat_q   <= osat_d;
      end
    end
  end

  assign dat_o       = dat_q;
  assign dat_valid_o = vo_q;
  assign int_sat_o   = isat_o_q;
  assign out_sat_o   = osat_q;

endmodule
